// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and arbitrates the instruction-RAM port between fetch and loader.
// Optional performance counters are enabled by defining IF_FETCH_CTRL_PERF_EN.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned LD_CNT_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [31:0]         npc,
  input  logic                ld_req,
  input  logic                ld_valid,
  input  logic                ld_last,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [31:0]         ld_data,
  output logic                ld_gnt,
  output logic [LD_CNT_W-1:0] ld_words,
  output logic [31:0]         pc,
  output logic                ram_ena,
  output logic                ram_wena,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  output logic                inst_valid,
  output logic [31:0]         inst_pc
`ifdef IF_FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_fetch,
  output logic [31:0]         perf_stall
`endif
);

  typedef enum logic [2:0] {BOOT, RUN, HOLD, LOAD, REFILL} state_t;

  state_t              state;
  logic                ram_ena_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [31:0]         ram_wdata_q;
  logic                load_exit;

  // While the loader owns the port, the RAM strobes follow it directly.
  assign ram_ena   = (state == LOAD) ? ld_valid : ram_ena_q;
  assign ram_wena  = (state == LOAD) && ld_valid;
  assign ram_addr  = (state == LOAD) ? ld_addr  : ram_addr_q;
  assign ram_wdata = (state == LOAD) ? ld_data  : ram_wdata_q;

  assign load_exit = (ld_valid && ld_last) || !ld_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      inst_pc     <= RESET_PC;
      inst_valid  <= 1'b0;
      ld_gnt      <= 1'b0;
      ld_words    <= '0;
      ram_ena_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          ram_ena_q  <= 1'b1;
          ram_addr_q <= pc[ADDR_W+1:2];
        end
        RUN: begin
          // Load beats stall; either way the read issued this cycle is discarded.
          if (ld_req) begin
            state      <= LOAD;
            ld_gnt     <= 1'b1;
            ld_words   <= '0;
            inst_valid <= 1'b0;
            ram_ena_q  <= 1'b0;
          end else if (stall) begin
            state     <= HOLD;
            ram_ena_q <= 1'b0;
          end else begin
            pc         <= npc;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            ram_addr_q <= npc[ADDR_W+1:2];
          end
        end
        HOLD: begin
          if (ld_req) begin
            state      <= LOAD;
            ld_gnt     <= 1'b1;
            ld_words   <= '0;
            inst_valid <= 1'b0;
          end else if (!stall) begin
            state      <= RUN;
            ram_ena_q  <= 1'b1;
            ram_addr_q <= pc[ADDR_W+1:2];
          end
        end
        LOAD: begin
          if (ld_valid) begin
            ram_wdata_q <= ld_data;
            if (ld_words != '1) ld_words <= ld_words + LD_CNT_W'(1);
          end
          if (load_exit) begin
            state      <= REFILL;
            ld_gnt     <= 1'b0;
            ram_ena_q  <= 1'b1;
            ram_addr_q <= pc[ADDR_W+1:2];
          end
        end
        REFILL: begin
          state      <= RUN;
          inst_pc    <= pc;
          inst_valid <= 1'b1;
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef IF_FETCH_CTRL_PERF_EN
  // Every RUN cycle issues a read; every HOLD cycle is a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (state == RUN)  perf_fetch <= perf_fetch + 32'd1;
      if (state == HOLD) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: sequential fetch, stall, load bursts, reset mid-load, dropped request.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, stall, ld_req, ld_valid, ld_last;
  logic [31:0] npc, ld_data;
  logic [9:0]  ld_addr;
  logic        ld_gnt;
  logic [9:0]  ld_words;
  logic [31:0] pc;
  logic        ram_ena, ram_wena;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
`ifdef IF_FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Sequential-PC datapath model.
  assign npc = pc + 32'd4;

  if_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .npc(npc),
    .ld_req(ld_req), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_gnt(ld_gnt), .ld_words(ld_words), .pc(pc),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .inst_valid(inst_valid), .inst_pc(inst_pc)
`ifdef IF_FETCH_CTRL_PERF_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; ld_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_addr = '0; ld_data = '0;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
    checks++; if (ld_gnt !== 1'b0 || ld_words !== 10'd0) begin errors++; $display("FAIL reset_ld got gnt=%b words=%0d want 0/0", ld_gnt, ld_words); end
    checks++; if ({ram_ena, ram_wena} !== 2'b00) begin errors++; $display("FAIL reset_ram_en got %b%b want 00", ram_ena, ram_wena); end
    checks++; if (ram_addr !== 10'd0 || ram_wdata !== 32'd0) begin errors++; $display("FAIL reset_ram_bus got addr=%h data=%h want 0/0", ram_addr, ram_wdata); end
  endtask

  task automatic test_sequential();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, 32'(i * 4)); end
      checks++; if (inst_valid !== (i > 0)) begin errors++; $display("FAIL seq_inst_valid[%0d] got %b want %b", i, inst_valid, (i > 0)); end
      checks++; if (inst_pc !== ((i > 0) ? 32'((i - 1) * 4) : 32'h0)) begin errors++; $display("FAIL seq_inst_pc[%0d] got %h", i, inst_pc); end
      checks++; if (ram_ena !== 1'b1 || ram_addr !== 10'(i)) begin errors++; $display("FAIL seq_ram[%0d] got ena=%b addr=%0d want 1/%0d", i, ram_ena, ram_addr, i); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_pc[%0d] got %h want 10", i, pc); end
      checks++; if (ram_ena !== 1'b0) begin errors++; $display("FAIL stall_ram_ena[%0d] got %b want 0", i, ram_ena); end
      checks++; if (inst_pc !== 32'h0C || inst_valid !== 1'b1) begin errors++; $display("FAIL stall_inst[%0d] got %h/%b want 0c/1", i, inst_pc, inst_valid); end
    end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h10 || ram_ena !== 1'b1 || ram_addr !== 10'd4) begin errors++; $display("FAIL stall_release got pc=%h ena=%b addr=%0d want 10/1/4", pc, ram_ena, ram_addr); end
    tick();
    checks++; if (pc !== 32'h14 || inst_pc !== 32'h10) begin errors++; $display("FAIL stall_resume got pc=%h inst_pc=%h want 14/10", pc, inst_pc); end
`ifdef IF_FETCH_CTRL_PERF_EN
    checks++; if (perf_stall !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d want 3", perf_stall); end
`endif
    tick(); tick(); tick();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL pre_load_pc got %h want 20", pc); end
  endtask

  task automatic test_load_with_stall();
    ld_req = 1'b1; stall = 1'b1; ld_valid = 1'b1; ld_addr = 10'd7; ld_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (ram_wena !== 1'b0) begin errors++; $display("FAIL early_valid_write got %b want 0", ram_wena); end
    tick();
    checks++; if (ld_gnt !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL load_entry got gnt=%b iv=%b want 1/0", ld_gnt, inst_valid); end
    checks++; if (pc !== 32'h20 || ld_words !== 10'd0) begin errors++; $display("FAIL load_entry_pc got pc=%h words=%0d want 20/0", pc, ld_words); end
`ifdef IF_FETCH_CTRL_PERF_EN
    checks++; if (perf_fetch !== 32'd10) begin errors++; $display("FAIL perf_fetch got %0d want 10", perf_fetch); end
`endif
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = 10'(i); ld_data = 32'hA0 + 32'(i); ld_last = (i == 3);
      #1;
      checks++; if ({ram_ena, ram_wena} !== 2'b11 || ram_addr !== 10'(i) || ram_wdata !== 32'hA0 + 32'(i))
        begin errors++; $display("FAIL load_write[%0d] got en=%b%b addr=%0d data=%h", i, ram_ena, ram_wena, ram_addr, ram_wdata); end
      tick();
      checks++; if (ld_words !== 10'(i + 1)) begin errors++; $display("FAIL load_words[%0d] got %0d want %0d", i, ld_words, i + 1); end
    end
    checks++; if (ld_gnt !== 1'b0 || ram_ena !== 1'b1 || ram_wena !== 1'b0 || ram_addr !== 10'd8)
      begin errors++; $display("FAIL refill got gnt=%b en=%b%b addr=%0d want 0/10/8", ld_gnt, ram_ena, ram_wena, ram_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL refill_iv got %b want 0", inst_valid); end
    ld_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || pc !== 32'h20) begin errors++; $display("FAIL refill_done got iv=%b inst_pc=%h pc=%h want 1/20/20", inst_valid, inst_pc, pc); end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h24 || inst_pc !== 32'h20) begin errors++; $display("FAIL post_load got pc=%h inst_pc=%h want 24/20", pc, inst_pc); end
  endtask

  task automatic test_reset_mid_load();
    ld_req = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_addr = 10'(20 + i); ld_data = 32'h55 + 32'(i);
      tick();
    end
    checks++; if (ld_words !== 10'd2 || ld_gnt !== 1'b1) begin errors++; $display("FAIL rml_pre got words=%0d gnt=%b want 2/1", ld_words, ld_gnt); end
    rst_n = 1'b0; ld_valid = 1'b0;
    tick();
    checks++; if (ld_gnt !== 1'b0 || ram_wena !== 1'b0 || ram_ena !== 1'b0) begin errors++; $display("FAIL rml_abort got gnt=%b en=%b%b want 0/00", ld_gnt, ram_ena, ram_wena); end
    checks++; if (pc !== 32'h0 || ld_words !== 10'd0) begin errors++; $display("FAIL rml_state got pc=%h words=%0d want 0/0", pc, ld_words); end
    rst_n = 1'b1; ld_req = 1'b0; ld_valid = 1'b1;
    #1;
    checks++; if (ram_wena !== 1'b0) begin errors++; $display("FAIL boot_write got %b want 0", ram_wena); end
    tick();
    checks++; if (ram_wena !== 1'b0 || ld_gnt !== 1'b0 || pc !== 32'h0 || ram_ena !== 1'b1)
      begin errors++; $display("FAIL boot_run got wena=%b gnt=%b pc=%h ena=%b", ram_wena, ld_gnt, pc, ram_ena); end
    ld_valid = 1'b0;
  endtask

  task automatic test_drop_mid_burst();
    tick();
    ld_req = 1'b1;
    tick();
    checks++; if (ld_gnt !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL drop_entry got gnt=%b pc=%h want 1/4", ld_gnt, pc); end
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_addr = 10'(16 + i); ld_data = 32'h77 + 32'(i);
      tick();
    end
    ld_valid = 1'b0; ld_req = 1'b0;
    #1;
    checks++; if ({ram_ena, ram_wena} !== 2'b00) begin errors++; $display("FAIL drop_no_write got en=%b%b want 00", ram_ena, ram_wena); end
    tick();
    checks++; if (ld_gnt !== 1'b0 || ld_words !== 10'd2) begin errors++; $display("FAIL drop_refill got gnt=%b words=%0d want 0/2", ld_gnt, ld_words); end
    checks++; if (ram_ena !== 1'b1 || ram_addr !== 10'd1 || pc !== 32'h4) begin errors++; $display("FAIL drop_refill_rd got en=%b addr=%0d pc=%h want 1/1/4", ram_ena, ram_addr, pc); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || pc !== 32'h4) begin errors++; $display("FAIL drop_run got iv=%b inst_pc=%h pc=%h want 1/4/4", inst_valid, inst_pc, pc); end
    tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL drop_advance got %h want 8", pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_load_with_stall();
    test_reset_mid_load();
    test_drop_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
